param_mem_ctrl: RTL and testbench

// - Parametrised single-port memory with valid/ready request port, byte-enable writes,

---
 rtl/param_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_param_mem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_mem_ctrl.sv
// Parametrised single-port memory with valid/ready requests, byte-enable writes, pipelined
// read responses, range checking and a post-reset clear sweep. Optional MEM_PARITY_EN adds per-byte parity.
module param_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic                    init_done
`ifdef MEM_PARITY_EN
  ,
  input  logic                    par_inject
`endif
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    accept, in_range, mem_we, rd_err;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   rd_word, wr_word;
  logic                    s0_valid_q, s0_valid_d, s0_err_q, s0_err_d;
  logic [DATA_WIDTH-1:0]   s0_data_q, s0_data_d;

  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign rd_word  = in_range ? mem_q[req_addr] : '0;

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rd_par, wr_par;

  assign rd_par = in_range ? par_q[req_addr] : '0;

  // Even parity: the stored bit equals the XOR of the byte, so byte plus bit has even weight.
  always_comb begin
    rd_err = 1'b0;
    wr_par = rd_par;
    for (int i = 0; i < NB; i++) begin
      rd_err = rd_err | ((^rd_word[8*i +: 8]) ^ rd_par[i]);
      if (req_be[i]) wr_par[i] = ^req_wdata[8*i +: 8];
    end
    if (par_inject && req_be[0]) wr_par[0] = ~wr_par[0];
    if (state_q == ST_CLEAR) wr_par = '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) par_q[wr_addr] <= wr_par;
  end
`else
  assign rd_err = 1'b0;
`endif

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    req_ready = 1'b0;
    init_done = 1'b0;
    accept    = 1'b0;
    mem_we    = 1'b0;
    wr_addr   = req_addr;
    wr_word   = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (req_be[i]) wr_word[8*i +: 8] = req_wdata[8*i +: 8];
    end

    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      wr_addr   = clr_ptr_q;
      wr_word   = '0;
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_ADDR) begin
        state_d   = ST_RUN;
        clr_ptr_d = '0;
      end
    end else begin
      req_ready = 1'b1;
      init_done = 1'b1;
      accept    = req_valid;
      mem_we    = accept && req_we && in_range;
    end

    // Reads and every out-of-range request produce a response; in-range writes do not.
    s0_valid_d = accept && (!req_we || !in_range);
    s0_err_d   = s0_valid_d ? (!in_range || (!req_we && rd_err)) : s0_err_q;
    s0_data_d  = s0_valid_d ? rd_word : s0_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      s0_valid_q <= 1'b0;
      s0_err_q   <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      s0_valid_q <= s0_valid_d;
      s0_err_q   <= s0_err_d;
      s0_data_q  <= s0_data_d;
    end
  end

  // NOTE: storage has no reset branch; the clear sweep zeroes it over DEPTH cycles instead.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wr_addr] <= wr_word;
  end

  // Any RD_LATENCY other than 1 builds the two-stage response path.
  if (RD_LATENCY == 1) begin : g_lat1
    assign rsp_valid = s0_valid_q;
    assign rsp_err   = s0_err_q;
    assign rsp_data  = s0_data_q;
  end else begin : g_lat2
    logic                  rsp_valid_q, rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
      rsp_err_d  = s0_valid_q ? s0_err_q  : rsp_err_q;
      rsp_data_d = s0_valid_q ? s0_data_q : rsp_data_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_data_q  <= '0;
      end else begin
        rsp_valid_q <= s0_valid_q;
        rsp_err_q   <= rsp_err_d;
        rsp_data_q  <= rsp_data_d;
      end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
  end

endmodule

// File: tb/tb_param_mem_ctrl.sv
// Bench for param_mem_ctrl (DEPTH=12, RD_LATENCY=LAT): directed vector table, hand-written
// reset/clear sequences, and randomized traffic checked against a cycle-level reference model.
module tb_param_mem_ctrl;
  parameter int LAT = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NB-1:0] req_be = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          init_done;
`ifdef MEM_PARITY_EN
  logic          par_inject = 1'b0;
`endif

  param_mem_ctrl #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .RD_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .init_done(init_done)
`ifdef MEM_PARITY_EN
    ,
    .par_inject(par_inject)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Reference model: word array, per-word "byte 0 parity corrupted" flag, and a queue of
  // expected responses stamped with the negedge index at which they must be visible.
  typedef struct { int due; logic [DW-1:0] data; logic err; } exp_t;
  typedef struct { logic [DW-1:0] data; logic err; } rsp_t;

  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_bad [DEPTH];
  exp_t          exp_q[$];
  exp_t          mon_e;
  rsp_t          rsp_log[$];
  int            cyc = 0, sweep_cnt = 0, run_len = 0, max_run = 0;
  logic [DW-1:0] last_data = '0;
  bit            mon_en = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      check("ready_init", {req_ready, init_done}, (sweep_cnt >= DEPTH) ? 2'b11 : 2'b00);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        check("rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, mon_e.err, mon_e.data});
        last_data = mon_e.data;
      end else begin
        check("rsp_idle", {rsp_valid, rsp_data}, {1'b0, last_data});
      end
    end
    if (rsp_valid === 1'b1) begin
      rsp_log.push_back('{rsp_data, rsp_err});
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    // Inputs seen now are what the next rising edge samples.
    if (rst) begin
      exp_q.delete();
      sweep_cnt = 0;
      last_data = '0;
      for (int a = 0; a < DEPTH; a++) begin
        mdl_mem[a] = '0;
        mdl_bad[a] = 1'b0;
      end
      mon_en = 1'b1;
    end else begin
      if (req_valid && sweep_cnt >= DEPTH) begin
        if (int'(req_addr) >= DEPTH) begin
          exp_q.push_back('{cyc + LAT, '0, 1'b1});
        end else if (req_we) begin
          for (int b = 0; b < NB; b++)
            if (req_be[b]) mdl_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
`ifdef MEM_PARITY_EN
          if (req_be[0]) mdl_bad[req_addr] = par_inject;
`endif
        end else begin
          exp_q.push_back('{cyc + LAT, mdl_mem[req_addr], logic'(mdl_bad[req_addr])});
        end
      end
      if (sweep_cnt < DEPTH) sweep_cnt++;
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] be;
    logic          exp_rsp;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input int addr, input logic [DW-1:0] wdata,
                     input logic [NB-1:0] be, input logic exp_rsp,
                     input logic [DW-1:0] exp_data, input logic exp_err);
    vecs.push_back('{we, AW'(addr), wdata, be, exp_rsp, exp_data, exp_err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [NB-1:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    check("wait_ready", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;

    // Reads right after the clear sweep must return zero.
    for (int a = 0; a < DEPTH; a++) add(1'b0, a, '0, '0, 1'b1, '0, 1'b0);
    add(1'b1, 3,  32'hDEADBEEF, 4'hF,    1'b0, '0,           1'b0);
    add(1'b0, 3,  '0,           '0,      1'b1, 32'hDEADBEEF, 1'b0);
    add(1'b1, 3,  32'h11223344, 4'b0101, 1'b0, '0,           1'b0);
    add(1'b0, 3,  '0,           '0,      1'b1, 32'hDE22BE44, 1'b0);
    add(1'b1, 3,  32'hFFFFFFFF, 4'h0,    1'b0, '0,           1'b0);
    add(1'b0, 3,  '0,           '0,      1'b1, 32'hDE22BE44, 1'b0);
    add(1'b0, 13, '0,           '0,      1'b1, '0,           1'b1);
    add(1'b1, 14, 32'hCAFEF00D, 4'hF,    1'b1, '0,           1'b1);
    add(1'b1, 5,  32'h00000005, 4'hF,    1'b0, '0,           1'b0);
    add(1'b0, 5,  '0,           '0,      1'b1, 32'h00000005, 1'b0);
    for (int a = 0; a < 16; a++)
      add(1'b0, a, '0, '0, 1'b1,
          (a == 3) ? 32'hDE22BE44 : (a == 5) ? 32'h00000005 : 32'h0, a >= DEPTH);

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    wait_ready();

    // Dirty every word, then pulse reset and time the clear sweep.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, AW'(a), 32'hA5A5A5A5, 4'hF);
      tick();
    end
    idle(LAT + 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin
      n++;
      tick();
    end
    check("clear_cycles", n, DEPTH);

    rsp_log.delete();
    max_run = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      tick();
    end
    idle(LAT + 2);
    n = 0;
    foreach (vecs[i]) if (vecs[i].exp_rsp) n++;
    check("table_rsp_count", rsp_log.size(), n);
    k = 0;
    foreach (vecs[i]) begin
      if (vecs[i].exp_rsp) begin
        if (k < rsp_log.size())
          check($sformatf("vec%0d", i), {rsp_log[k].err, rsp_log[k].data},
                {vecs[i].exp_err, vecs[i].exp_data});
        k++;
      end
    end
    check("stream_run", max_run, 17);

    // Reset on the edge after a read is accepted: no response may follow the reset.
    drive(1'b0, 4'd3, '0, '0);
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    repeat (DEPTH + 4) begin
      if (rsp_valid) n++;
      tick();
    end
    check("rst_kill", n, 0);
    wait_ready();

`ifdef MEM_PARITY_EN
    rsp_log.delete();
    par_inject = 1'b1;
    drive(1'b1, 4'd7, 32'h000000FF, 4'hF);
    tick();
    par_inject = 1'b0;
    drive(1'b0, 4'd7, '0, '0);
    tick();
    drive(1'b1, 4'd7, 32'h000000FF, 4'hF);
    tick();
    drive(1'b0, 4'd7, '0, '0);
    tick();
    idle(LAT + 2);
    check("par_count", rsp_log.size(), 2);
    if (rsp_log.size() >= 2) begin
      check("par_bad",  {rsp_log[0].err, rsp_log[0].data}, {1'b1, 32'h000000FF});
      check("par_good", {rsp_log[1].err, rsp_log[1].data}, {1'b0, 32'h000000FF});
    end
`endif

    repeat (400) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 15));
      req_wdata = $urandom();
      req_be    = NB'($urandom_range(0, 15));
`ifdef MEM_PARITY_EN
      par_inject = ($urandom_range(0, 3) == 0);
`endif
      tick();
    end
    rst = 1'b0;
    idle(DEPTH + LAT + 4);
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
